// File: rtl/mult_q8_8_seq.sv
// Sequential signed fixed-point multiplier: sign-magnitude shift-add over WIDTH
// cycles, then round half away from zero and saturate to WIDTH-bit signed.
module mult_q8_8_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [AW-1:0] HALF    = AW'(1) << (FRAC - 1);
    localparam logic [AW-1:0] NEG_MAX = AW'(1) << (WIDTH - 1);
    localparam logic [AW-1:0] POS_MAX = NEG_MAX - AW'(1);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t            state, state_nx;
    logic              sign;
    logic [AW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [AW-1:0]     acc;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [AW-1:0]     rnd_sum, m;
    logic [WIDTH-1:0]  res_p;
    logic              res_o;

    // Negating the most negative value yields its own bit pattern, which read
    // unsigned is exactly the required magnitude.
    assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (in_valid) state_nx = CALC;
            CALC:  if (cnt == LAST) state_nx = ROUND;
            ROUND: state_nx = DONE;
            DONE:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    assign rnd_sum = acc + HALF;
    assign m       = rnd_sum >> FRAC;

    always_comb begin
        res_p = '0;
        res_o = 1'b0;
        if (!sign) begin
            if (m > POS_MAX) begin
                res_p = {1'b0, {(WIDTH-1){1'b1}}};
                res_o = 1'b1;
            end else begin
                res_p = m[WIDTH-1:0];
            end
        end else begin
            if (m > NEG_MAX) begin
                res_p = {1'b1, {(WIDTH-1){1'b0}}};
                res_o = 1'b1;
            end else begin
                res_p = WIDTH'(0) - m[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign   <= a[WIDTH-1] ^ b[WIDTH-1];
                    mcand  <= {{WIDTH{1'b0}}, a_mag};
                    mplier <= b_mag;
                    acc    <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    // Ends at WIDTH, well inside CW bits, so it never wraps.
                    cnt    <= cnt + CW'(1);
                end
                ROUND: begin
                    product <= res_p;
                    ovf     <= res_o;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_q8_8_seq.sv
// Scoreboard bench for mult_q8_8_seq: directed corner cases, backpressure,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_mult_q8_8_seq;

    localparam int NUM_RAND = 2500;
    localparam int LAT      = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic        ovf;

    mult_q8_8_seq #(.WIDTH(16), .FRAC(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        o;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    logic prev_v = 1'b0;

    initial forever @(posedge clk) cyc++;

    // Signed product, round half away from zero on the magnitude, saturate.
    function automatic void ref_mul(input logic [15:0] ra, input logic [15:0] rb,
                                    output logic [15:0] rp, output logic ro);
        longint full, mag, m;
        full = longint'($signed(ra)) * longint'($signed(rb));
        mag  = (full < 0) ? -full : full;
        m    = (mag + 128) / 256;
        ro   = 1'b0;
        if (full < 0) begin
            if (m > 32768) begin rp = 16'h8000; ro = 1'b1; end
            else rp = 16'(-m);
        end else begin
            if (m > 32767) begin rp = 16'h7FFF; ro = 1'b1; end
            else rp = 16'(m);
        end
    endfunction

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: drives out_ready, checks latency on out_valid rise and data on handshake.
    initial forever begin
        @(negedge clk);
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) check1("unexpected_out_valid", 32'd1, 32'd0);
                else check1("latency", cyc, sb[0].acc_cyc + LAT);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (product !== e.p || ovf !== e.o) begin
                    failures++;
                    $display("FAIL result a=%h b=%h: got product=%h ovf=%b expected product=%h ovf=%b",
                             e.a, e.b, product, ovf, e.p, e.o);
                end
            end
            prev_v = out_valid;
        end
    end

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
        int   t;
        logic ok;
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; in_valid = 1'b1;
        ok = 1'b0;
        t = 0;
        while (!ok && t < 200) begin
            if (in_ready) begin
                e.a = ia; e.b = ib;
                ref_mul(ia, ib, e.p, e.o);
                e.acc_cyc = cyc + 1;
                sb.push_back(e);
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
                t++;
            end
        end
        if (!ok) check1("accept_timeout", 32'd0, 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check1("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] hold_p;
        logic        hold_o;
        int          t;

        // Reset state
        #12;
        check1("rst_in_ready", in_ready, 1);
        check1("rst_out_valid", out_valid, 0);
        check1("rst_product", product, 16'h0000);
        check1("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values
        issue(16'h0100, 16'h0100);
        issue(16'h0180, 16'hFF00);
        issue(16'h7FFF, 16'h7FFF);
        issue(16'h8000, 16'h8000);
        issue(16'h8000, 16'h0100);
        issue(16'h0001, 16'h0080);
        issue(16'hFFFF, 16'h0080);
        issue(16'h0001, 16'h007F);
        issue(16'h0000, 16'h8000);
        issue(16'hFF80, 16'h0001);
        drain();

        // Backpressure: result must hold, further operands ignored
        rdy_mode = 2;
        issue(16'h0300, 16'hFE00);
        t = 0;
        while (!out_valid && t < 40) begin @(negedge clk); t++; end
        check1("bp_out_valid_seen", out_valid, 1);
        hold_p = product;
        hold_o = ovf;
        check1("bp_value", hold_p, 16'hFA00);
        repeat (5) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            check1("bp_out_valid", out_valid, 1);
            check1("bp_in_ready", in_ready, 0);
            check1("bp_product_hold", product, hold_p);
            check1("bp_ovf_hold", ovf, hold_o);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 rdy_mode = 1;
        @(negedge clk);
        check1("bp_valid_before_release", out_valid, 1);
        @(negedge clk);
        check1("bp_valid_after_release", out_valid, 0);
        check1("bp_idle_after_release", in_ready, 1);
        drain();

        // Asynchronous reset mid-calculation aborts the operation
        issue(16'h1234, 16'h0567);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check1("abort_out_valid", out_valid, 0);
        check1("abort_in_ready", in_ready, 1);
        check1("abort_product", product, 16'h0000);
        check1("abort_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0200, 16'h0300);
        drain();

        // Randomized operands with random downstream stalls
        rdy_mode = 0;
        for (int i = 0; i < NUM_RAND; i++) begin
            logic [15:0] ra, rb;
            if (i % 2 == 0) begin
                ra = 16'($urandom); rb = 16'($urandom);
            end else begin
                ra = 16'($signed(11'($urandom)));
                rb = 16'($signed(11'($urandom)));
            end
            issue(ra, rb);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        rdy_mode = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
